// File: rtl/edge_point_collector.sv
// Tags the sampled pixel stream with raster coordinates, keeps valid edge points in a FIFO
// and serialises each one as a header/a/b record on a 32-bit valid/ready stream.
module edge_point_collector #(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 320,
  parameter int FIFO_DEPTH = 16,
  parameter bit KEEP_ALL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ab_start,
  input  logic [31:0] result_a,
  input  logic [31:0] result_b,
  input  logic        adivbyzero,
  input  logic        bdivbyzero,
  input  logic [3:0]  state,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_done,
  output logic [15:0] edge_count,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0]    X_LAST  = 10'(IMG_W - 1);
  localparam logic [9:0]    Y_LAST  = 10'(IMG_H - 1);
  localparam logic [CW-1:0] OCC_MAX = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [9:0]  y;
    logic [9:0]  x;
    logic [3:0]  st;
    logic        adz;
    logic        bdz;
    logic [31:0] a;
    logic [31:0] b;
  } rec_t;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_A, S_B} ser_t;

  function automatic logic [31:0] header(input rec_t r);
    return {r.y, r.x, r.st, 6'b0, r.adz, r.bdz};
  endfunction

  // ---------------- sample stage ----------------
  logic [9:0] x_q, y_q;
  logic       s1_vld_q, s1_first_q, frame_done_q;
  rec_t       s1_rec_q;
  logic       keep;

  assign keep = KEEP_ALL || ((state != 4'd0) && !adivbyzero && !bdivbyzero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      s1_vld_q     <= 1'b0;
      s1_first_q   <= 1'b0;
      frame_done_q <= 1'b0;
      s1_rec_q     <= '0;
    end else begin
      s1_vld_q     <= ab_start && keep;
      s1_first_q   <= ab_start && (x_q == 10'd0) && (y_q == 10'd0);
      frame_done_q <= ab_start && (x_q == X_LAST) && (y_q == Y_LAST);
      if (ab_start) begin
        s1_rec_q <= '{y: y_q, x: x_q, st: state, adz: adivbyzero, bdz: bdivbyzero,
                      a: result_a, b: result_b};
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  // ---------------- record FIFO ----------------
  ser_t          state_q;
  logic [CW-1:0] fifo_cnt_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  rec_t          mem_q [FIFO_DEPTH];
  rec_t          fifo_rd;
  logic [CW-1:0] occ;
  logic          fifo_empty, busy, wr_en, drop, pop;
  logic [15:0]   edge_cnt_q;
  logic          overflow_q;

  // The record held by the serializer still occupies a slot until its last beat leaves,
  // so total capacity in flight is exactly FIFO_DEPTH records.
  assign busy       = (state_q != S_IDLE);
  assign occ        = fifo_cnt_q + CW'(busy);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign wr_en      = s1_vld_q && (occ < OCC_MAX);
  assign drop       = s1_vld_q && !(occ < OCC_MAX);
  assign fifo_rd    = mem_q[rd_ptr_q];
  assign pop        = !fifo_empty && ((state_q == S_IDLE) || ((state_q == S_B) && out_ready));

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= s1_rec_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      edge_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      fifo_cnt_q <= fifo_cnt_q + CW'(wr_en) - CW'(pop);
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop)  overflow_q <= 1'b1;
      if (s1_first_q)
        edge_cnt_q <= wr_en ? 16'd1 : 16'd0;
      else if (wr_en && (edge_cnt_q != 16'hFFFF))
        edge_cnt_q <= edge_cnt_q + 16'd1;
    end
  end

  // ---------------- serializer ----------------
  logic [31:0] cur_a_q, cur_b_q;
  logic [31:0] out_data_q;
  logic        out_valid_q, out_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_a_q     <= '0;
      cur_b_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            cur_a_q     <= fifo_rd.a;
            cur_b_q     <= fifo_rd.b;
            out_data_q  <= header(fifo_rd);
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            state_q     <= S_HDR;
          end
        end
        S_HDR: begin
          if (out_ready) begin
            out_data_q <= cur_a_q;
            state_q    <= S_A;
          end
        end
        S_A: begin
          if (out_ready) begin
            out_data_q <= cur_b_q;
            out_last_q <= 1'b1;
            state_q    <= S_B;
          end
        end
        S_B: begin
          if (out_ready) begin
            out_last_q <= 1'b0;
            if (!fifo_empty) begin
              cur_a_q    <= fifo_rd.a;
              cur_b_q    <= fifo_rd.b;
              out_data_q <= header(fifo_rd);
              state_q    <= S_HDR;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign edge_count = edge_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_edge_point_collector.sv
// Scoreboard bench for edge_point_collector on an 8x4 image; a second KEEP_ALL instance
// shares the pixel stream.
module tb_edge_point_collector;
  localparam int IW = 8;
  localparam int IH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ab_start = 1'b0;
  logic [31:0] result_a = '0, result_b = '0;
  logic        adivbyzero = 1'b0, bdivbyzero = 1'b0;
  logic [3:0]  state = '0;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_valid, out_last, frame_done, overflow;
  logic [15:0] edge_count;

  logic        k_ready = 1'b1;
  logic [31:0] k_data;
  logic        k_valid, k_last, k_frame_done, k_overflow;
  logic [15:0] k_edge_count;

  edge_point_collector #(.IMG_W(IW), .IMG_H(IH), .FIFO_DEPTH(16), .KEEP_ALL(1'b0)) dut (
    .clk(clk), .rst(rst), .ab_start(ab_start), .result_a(result_a), .result_b(result_b),
    .adivbyzero(adivbyzero), .bdivbyzero(bdivbyzero), .state(state),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_done(frame_done), .edge_count(edge_count), .overflow(overflow));

  edge_point_collector #(.IMG_W(IW), .IMG_H(IH), .FIFO_DEPTH(16), .KEEP_ALL(1'b1)) dut_k (
    .clk(clk), .rst(rst), .ab_start(ab_start), .result_a(result_a), .result_b(result_b),
    .adivbyzero(adivbyzero), .bdivbyzero(bdivbyzero), .state(state),
    .out_data(k_data), .out_valid(k_valid), .out_ready(k_ready), .out_last(k_last),
    .frame_done(k_frame_done), .edge_count(k_edge_count), .overflow(k_overflow));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pidx = 0;
  int recs_out = 0;
  int k_recs = 0;
  logic [32:0] exp_q[$];
  logic        hold_v = 1'b0;
  logic [32:0] hold_d;
  logic [32:0] mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [3:0] st, input logic adz, input logic bdz);
    logic [31:0] x, y;
    x = 32'(pidx % IW);
    y = 32'((pidx / IW) % IH);
    return (y << 22) | (x << 12) | ({28'd0, st} << 8) | {30'd0, adz, bdz};
  endfunction

  task automatic pixel(input logic [3:0] st, input logic adz, input logic bdz,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit emit, input logic [31:0] hdr);
    if (emit) begin
      exp_q.push_back({1'b0, hdr});
      exp_q.push_back({1'b0, a});
      exp_q.push_back({1'b1, b});
    end
    ab_start = 1'b1; state = st; adivbyzero = adz; bdivbyzero = bdz;
    result_a = a; result_b = b;
    @(posedge clk); #1;
    ab_start = 1'b0;
    pidx++;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    cycles(2);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    pidx = 0;
  endtask

  // Monitor: pops expected beats on every accepted beat; checks hold-stability while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else if (out_valid) begin
      if (hold_v) chk("stall_stable", {31'd0, out_last, out_data}, {31'd0, hold_d});
      if (out_ready) begin
        hold_v = 1'b0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got=%0h expected=none", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", {31'd0, out_last, out_data}, {31'd0, mon_e});
          if (out_last) recs_out++;
        end
      end else begin
        hold_v = 1'b1;
        hold_d = {out_last, out_data};
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  always @(negedge clk) if (!rst && k_valid && k_ready && k_last) k_recs++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0;
    do_reset();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_edge_count", 64'(edge_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    // single edge at idx 5 with latency check
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) pixel(4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    pixel(4'd5, 1'b0, 1'b0, 32'h00010000, 32'hFFFF8000, 1'b1, 32'h00005500);
    chk("lat_t0", 64'(out_valid), 64'd0);
    cycles(1);
    chk("lat_t1", 64'(out_valid), 64'd0);
    cycles(1);
    chk("lat_t2", 64'(out_valid), 64'd1);
    wait_drain(20);
    chk("single_edge_count", 64'(edge_count), 64'd1);

    // filtering
    pixel(4'd0, 1'b0, 1'b0, 32'h11, 32'h22, 1'b0, 32'h0);
    pixel(4'd2, 1'b1, 1'b0, 32'h33, 32'h44, 1'b0, 32'h0);
    pixel(4'd2, 1'b0, 1'b1, 32'h55, 32'h66, 1'b0, 32'h0);
    cycles(40);
    chk("filter_valid", 64'(out_valid), 64'd0);
    chk("filter_edge_count", 64'(edge_count), 64'd1);
    chk("keepall_edge_count", 64'(k_edge_count), 64'd9);
    chk("keepall_records", 64'(k_recs), 64'd9);

    // backpressure: 3 edges, stall 10 cycles, then toggle ready
    out_ready = 1'b0;
    r0 = recs_out;
    pixel(4'd1, 1'b0, 1'b0, 32'hA0000001, 32'hB0000001, 1'b1, 32'h00401100);
    pixel(4'd2, 1'b0, 1'b0, 32'hA0000002, 32'hB0000002, 1'b1, mk_hdr(4'd2, 1'b0, 1'b0));
    pixel(4'd3, 1'b0, 1'b0, 32'hA0000003, 32'hB0000003, 1'b1, mk_hdr(4'd3, 1'b0, 1'b0));
    cycles(10);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_hdr", 64'(out_data), 64'h00401100);
    for (int n = 0; n < 80 && (exp_q.size() != 0 || out_valid); n++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("bp_left", 64'(exp_q.size()), 64'd0);
    chk("bp_records", 64'(recs_out - r0), 64'd3);
    chk("bp_edge_count", 64'(edge_count), 64'd4);

    // overflow: 18 edges with consumer stalled, fresh frame
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++)
      pixel(4'd4, 1'b0, 1'b0, 32'h100 + 32'(i), ~(32'h100 + 32'(i)), i < 16, mk_hdr(4'd4, 1'b0, 1'b0));
    cycles(3);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_edge_count", 64'(edge_count), 64'd16);
    r0 = recs_out;
    out_ready = 1'b1;
    wait_drain(200);
    chk("ovf_records", 64'(recs_out - r0), 64'd16);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // frame wrap at idx 31
    for (int i = 18; i < 31; i++) pixel(4'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("fd_before", 64'(frame_done), 64'd0);
    pixel(4'd3, 1'b0, 1'b0, 32'hCAFE0001, 32'h0000BEEF, 1'b1, 32'h00C07300);
    chk("fd_pulse", 64'(frame_done), 64'd1);
    cycles(1);
    chk("fd_after", 64'(frame_done), 64'd0);
    chk("wrap_edge_count_pre", 64'(edge_count), 64'd17);
    pixel(4'd6, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000600);
    wait_drain(40);
    chk("wrap_edge_count_new", 64'(edge_count), 64'd1);

    // reset mid-record after header accepted
    pixel(4'd7, 1'b0, 1'b0, 32'h0000A5A5, 32'h00005A5A, 1'b1, 32'h00001700);
    for (int n = 0; n < 10 && !out_valid; n++) begin @(posedge clk); #1; end
    chk("mid_hdr_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    chk("mid_rst_edge_count", 64'(edge_count), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    cycles(2);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    pidx = 0;
    pixel(4'd9, 1'b0, 1'b0, 32'h00000001, 32'h00000002, 1'b1, 32'h00000900);
    wait_drain(40);
    chk("post_rst_edge_count", 64'(edge_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
